mux_sel_sched: RTL and testbench
================================

# mux_sel_sched

Synchronous select scheduler for a bank of delay-modelled 2:1 mux cells arranged as an N_IN:1 phase/clock selection tree in the analog core. It accepts select-change requests over a valid/ready handshake and sequences each change glitch-free: gate the tree output, wait for in-flight edges to drain, switch the select, wait for the mux delay/jitter to settle, then ungate and acknowledge. An optional sweep mode steps through all inputs with a programmable dwell, for phase calibration.

## Interface
- N_IN, 16: number of selectable inputs; power of two, at least 2.
- SEL_W, $clog2(N_IN): select width.
- GATE_CYC, 4: cycles the output is gated before the select changes; at least 1.
- SETTLE_CYC, 8: cycles after the select change before ungating; at least 1.
- CNT_W, 8: width of the internal counters and of dwell.
- Elaboration error if GATE_CYC or SETTLE_CYC is 0, or either exceeds 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge. One clock domain only.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  select-change request valid.
- req_sel  in  SEL_W  requested input index.
- req_ready  out  1  scheduler can accept a request.
- sweep_en  in  1  enables auto-sweep while idle.
- dwell  in  CNT_W  idle cycles between sweep steps; 0 is treated as 1.
- sel  out  SEL_W  registered select to the mux tree.
- gate_en  out  1  1 passes the mux-tree output; 0 forces it low.
- busy  out  1  a switch sequence is in progress.
- done  out  1  one-cycle pulse when a request completes.
- err  out  1  one-cycle pulse when an out-of-range request is dropped.

## Operation
- States: IDLE, GATE, SETTLE. A 2-bit encoding is sufficient.
- **Reset values.** sel=0, gate_en=1, req_ready=0, busy=0, done=0, err=0, state=IDLE, counters cleared.
- **First edge after reset.** On the first edge with rst low, req_ready becomes 1.
- **Accept rule.** A request is accepted at an edge where req_valid && req_ready. The target is latched from req_sel.
- **Accept, in range, target != sel.**
  - state<=GATE, gate_en<=0, busy<=1, req_ready<=0.
  - cnt<=GATE_CYC-1.
- **Accept, target == sel.** No gating. done<=1 for one cycle. State stays IDLE and req_ready stays 1.
- **Accept, req_sel >= N_IN.** Only reachable when N_IN is not a power of two; the index guard is still implemented. The request is consumed: err<=1 for one cycle, sel is unchanged, done is not asserted.
- **GATE.** Decrement cnt. At cnt==0: sel<=target, state<=SETTLE, cnt<=SETTLE_CYC-1.
- **SETTLE.** Decrement cnt. At cnt==0: gate_en<=1, done<=1, busy<=0, req_ready<=1, state<=IDLE.
- **Sweep.**
  - In IDLE with sweep_en=1 and req_valid=0, a dwell counter counts idle cycles.
  - When it reaches max(dwell,1), an internal request is issued for (sel+1) mod N_IN and follows the normal path. The wrap is N_IN-1 -> 0.
  - An external req_valid in the same cycle wins and the dwell counter clears.
  - Deasserting sweep_en clears the dwell counter. A sequence already in progress completes.
- **Mid-sequence inputs.** req_valid and sweep_en have no effect outside IDLE; req_ready=0 there.
- **Reset mid-sequence.** The next edge with rst=1 applies the reset values. The pending target is discarded and no done is issued.

## Timing
- Reference edge: accept at edge k.
  - gate_en=0 from edge k until edge k+GATE_CYC+SETTLE_CYC.
  - sel changes at edge k+GATE_CYC.
  - gate_en=1, done=1 and req_ready=1 all at edge k+GATE_CYC+SETTLE_CYC.
- A full switch therefore takes GATE_CYC+SETTLE_CYC cycles, and done is high for exactly one cycle.
- **Back-to-back requests.** The next request can be accepted at edge k+GATE_CYC+SETTLE_CYC+1, the first edge with req_ready=1.
- **Same-select and error paths.** done or err is high in the cycle after edge k. req_ready is never dropped, so throughput is one request per cycle.
- **Select stability.** sel never changes while gate_en=1, and it changes at most once per sequence.
- **Sweep cadence.** Step period = max(dwell,1) + GATE_CYC + SETTLE_CYC cycles, counted from the done of one step to the done of the next.

## Test plan
- **Basic switch.** Reset, then request sel=5 with defaults -> gate_en low 12 cycles; sel=5 exactly 4 cycles after accept; done and gate_en high 12 cycles after accept.
- **No-op request.** Request sel=5 while sel=5 -> done one cycle later; gate_en stays 1; busy stays 0.
- **Ignored mid-sequence request.** Request 3, then hold req_valid with req_sel=9 during GATE -> req_sel=9 is not accepted until req_ready returns; final sel=9 after two full sequences.
- **Sweep wrap.** sweep_en=1, dwell=2, starting from sel=14 -> sel goes 15, 0, 1, with step period 14 cycles; no glitch (sel never changes while gate_en=1).
- **Reset during SETTLE.** Assert rst during SETTLE -> next edge gives sel=0, gate_en=1, busy=0, no done; req_ready=1 on the first edge after rst drops.
- **Out-of-range request.** Build with N_IN=12 and request sel=13 -> err pulses for one cycle, sel unchanged, done never asserted.

Source files
------------

// File: rtl/mux_sel_sched.sv
// mux_sel_sched: glitch-free select sequencer for an N_IN:1 mux tree.
// A select change gates the tree output, waits for in-flight edges to drain,
// switches sel, waits for the mux delay to settle, then ungates and acks.
// An optional sweep mode steps sel through every input with a dwell gap.
module mux_sel_sched #(
  parameter int N_IN       = 16,
  parameter int SEL_W      = $clog2(N_IN),
  parameter int GATE_CYC   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  input  logic             sweep_en,
  input  logic [CNT_W-1:0] dwell,
  output logic [SEL_W-1:0] sel,
  output logic             gate_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (N_IN < 2 || GATE_CYC < 1 || SETTLE_CYC < 1 ||
      GATE_CYC > (1 << CNT_W) || SETTLE_CYC > (1 << CNT_W)) begin : g_param_err
    $error("mux_sel_sched: illegal N_IN/GATE_CYC/SETTLE_CYC/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // counters are loaded with (cycles - 1) so the phase ends on the cnt==0 edge
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] dcnt, dcnt_n;
  logic [SEL_W-1:0] tgt, tgt_n;
  logic [SEL_W-1:0] sel_n;
  logic             gate_n, ready_n, busy_n, done_n, err_n;

  logic [SEL_W-1:0] sel_inc;
  logic [CNT_W:0]   dwell_eff;
  logic [CNT_W:0]   dcnt_inc;
  logic             sweep_fire;
  logic             acc_valid;
  logic [SEL_W-1:0] acc_sel;

  // next sweep target wraps from the last input back to 0
  assign sel_inc    = (sel == SEL_W'(N_IN - 1)) ? '0 : sel + SEL_W'(1);
  // a dwell of 0 behaves as 1 so the sweep never stalls
  assign dwell_eff  = (dwell == '0) ? (CNT_W+1)'(1) : {1'b0, dwell};
  assign dcnt_inc   = {1'b0, dcnt} + (CNT_W+1)'(1);
  assign sweep_fire = sweep_en && !req_valid && (dcnt_inc >= dwell_eff);

  // next-state and registered-output decode
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dcnt_n    = dcnt;
    tgt_n     = tgt;
    sel_n     = sel;
    gate_n    = gate_en;
    ready_n   = req_ready;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = 1'b0;
    acc_valid = 1'b0;
    acc_sel   = req_sel;
    case (state)
      IDLE: begin
        if (!req_ready) begin
          // first edge out of reset only opens the handshake
          ready_n = 1'b1;
        end else begin
          if (req_valid) begin
            // external request wins over a pending sweep step
            acc_valid = 1'b1;
            acc_sel   = req_sel;
            dcnt_n    = '0;
          end else if (sweep_en) begin
            if (sweep_fire) begin
              acc_valid = 1'b1;
              acc_sel   = sel_inc;
              dcnt_n    = '0;
            end else begin
              dcnt_n = dcnt_inc[CNT_W-1:0];
            end
          end else begin
            dcnt_n = '0;
          end
          if (acc_valid) begin
            if ({1'b0, acc_sel} >= (SEL_W+1)'(N_IN)) begin
              err_n = 1'b1;
            end else if (acc_sel == sel) begin
              done_n = 1'b1;
            end else begin
              state_n = GATE;
              tgt_n   = acc_sel;
              gate_n  = 1'b0;
              busy_n  = 1'b1;
              ready_n = 1'b0;
              cnt_n   = GATE_LD;
            end
          end
        end
      end
      GATE: begin
        if (cnt == '0) begin
          sel_n   = tgt;
          state_n = SETTLE;
          cnt_n   = SETTLE_LD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          gate_n  = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      tgt       <= '0;
      sel       <= '0;
      gate_en   <= 1'b1;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      dcnt      <= dcnt_n;
      tgt       <= tgt_n;
      sel       <= sel_n;
      gate_en   <= gate_n;
      req_ready <= ready_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_sched.sv
// Bench for mux_sel_sched: directed steps plus random traffic, each edge
// compared against a timeline model (accept edge + fixed offsets).
module tb_mux_sel_sched;
  localparam int N  = 16;
  localparam int G  = 4;
  localparam int S  = 8;
  localparam int CW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [SW-1:0] req_sel = '0;
  logic          sweep_en = 1'b0;
  logic [CW-1:0] dwell = '0;
  logic          req_ready, gate_en, busy, done, err;
  logic [SW-1:0] sel;

  logic          v12 = 1'b0;
  logic [3:0]    s12 = '0;
  logic          rdy12, gate12, busy12, done12, err12;
  logic [3:0]    sel12;

  always #5 clk = ~clk;

  mux_sel_sched #(.N_IN(N), .GATE_CYC(G), .SETTLE_CYC(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .sweep_en(sweep_en), .dwell(dwell), .sel(sel),
    .gate_en(gate_en), .busy(busy), .done(done), .err(err)
  );

  mux_sel_sched #(.N_IN(12), .GATE_CYC(G), .SETTLE_CYC(S), .CNT_W(CW)) dut12 (
    .clk(clk), .rst(rst), .req_valid(v12), .req_sel(s12),
    .req_ready(rdy12), .sweep_en(1'b0), .dwell(8'd0), .sel(sel12),
    .gate_en(gate12), .busy(busy12), .done(done12), .err(err12)
  );

  int total = 0;
  int bad   = 0;

  // timeline model of the main instance
  int m_sel = 0, m_gate = 1, m_ready = 0, m_busy = 0, m_done = 0, m_err = 0;
  int in_seq = 0, acc = 0, tgt = 0, idle_cnt = 0, edge_n = 0;
  int prev_sel = 0, prev_gate = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start(input int t);
    in_seq  = 1;
    acc     = edge_n;
    tgt     = t;
    m_gate  = 0;
    m_busy  = 1;
    m_ready = 0;
  endtask

  // apply the rules for one edge using the inputs held across it
  task automatic model_edge();
    int d_eff;
    if (rst) begin
      m_sel = 0; m_gate = 1; m_ready = 0; m_busy = 0; m_done = 0; m_err = 0;
      in_seq = 0; idle_cnt = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (in_seq != 0) begin
        if (edge_n == acc + G) m_sel = tgt;
        if (edge_n == acc + G + S) begin
          in_seq = 0; m_gate = 1; m_done = 1; m_busy = 0; m_ready = 1;
        end
      end else if (m_ready == 0) begin
        m_ready = 1;
      end else if (req_valid) begin
        idle_cnt = 0;
        if (int'(req_sel) >= N) m_err = 1;
        else if (int'(req_sel) == m_sel) m_done = 1;
        else start(int'(req_sel));
      end else if (sweep_en) begin
        idle_cnt++;
        d_eff = (dwell == 0) ? 1 : int'(dwell);
        if (idle_cnt >= d_eff) begin
          idle_cnt = 0;
          start((m_sel + 1) % N);
        end
      end else begin
        idle_cnt = 0;
      end
    end
  endtask

  task automatic step();
    logic rst_at_edge;
    @(posedge clk);
    rst_at_edge = rst;
    edge_n++;
    model_edge();
    #1;
    chk("sel",   32'(sel),       m_sel);
    chk("gate",  32'(gate_en),   m_gate);
    chk("ready", 32'(req_ready), m_ready);
    chk("busy",  32'(busy),      m_busy);
    chk("done",  32'(done),      m_done);
    chk("err",   32'(err),       m_err);
    if (!rst_at_edge && edge_n > 1 && sel !== SW'(prev_sel))
      chk("glitch", {30'd0, 1'(prev_gate), gate_en}, 32'd0);
    prev_sel  = int'(sel);
    prev_gate = int'(gate_en);
  endtask

  task automatic wait_done(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) begin
        at = edge_n;
        break;
      end
    end
    if (at < 0) chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int ka, s_at, d_at, nd, d0, d1;
    int exp_sw[3];
    exp_sw[0] = 15; exp_sw[1] = 0; exp_sw[2] = 1;

    // reset
    rst = 1'b1;
    step(); step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("first_ready", 32'(req_ready), 32'd1);

    // basic switch to 5
    req_valid = 1'b1; req_sel = 4'd5;
    step();
    ka = edge_n;
    req_valid = 1'b0;
    s_at = -1; d_at = -1;
    for (int i = 0; i < G + S; i++) begin
      step();
      if (s_at < 0 && sel === 4'd5) s_at = edge_n;
      if (done === 1'b1) d_at = edge_n;
    end
    chk("sel_latency", s_at - ka, G);
    chk("done_latency", d_at - ka, G + S);

    // no-op request
    req_valid = 1'b1; req_sel = 4'd5;
    step();
    req_valid = 1'b0;
    chk("noop_done", 32'(done), 32'd1);
    chk("noop_gate", 32'(gate_en), 32'd1);
    step();
    chk("noop_done_clr", 32'(done), 32'd0);

    // request 3 then hold 9 through the sequence
    req_valid = 1'b1; req_sel = 4'd3;
    step();
    req_sel = 4'd9;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (done === 1'b1) nd++;
      if (done === 1'b1 && sel === 4'd9) break;
    end
    req_valid = 1'b0;
    chk("mid_dones", nd, 2);
    chk("mid_final", 32'(sel), 32'd9);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_sel   = ($urandom_range(0, 3) == 0) ? SW'(m_sel) : SW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) sweep_en = ~sweep_en;
      dwell = CW'($urandom_range(0, 3));
      step();
    end

    // sweep wrap from 14
    req_valid = 1'b0; sweep_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready === 1'b1) break;
      step();
    end
    req_valid = 1'b1; req_sel = 4'd14;
    step();
    req_valid = 1'b0;
    if (done === 1'b1) d0 = edge_n;
    else wait_done("to14_timeout", d0);
    sweep_en = 1'b1; dwell = 8'd2;
    for (int k = 0; k < 3; k++) begin
      wait_done("sweep_timeout", d1);
      chk("sweep_sel", 32'(sel), exp_sw[k]);
      chk("sweep_period", d1 - d0, 2 + G + S);
      d0 = d1;
    end
    sweep_en = 1'b0;
    step();

    // reset during SETTLE
    req_valid = 1'b1; req_sel = 4'd7;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < G + 2; i++) step();
    chk("rs_pre_sel", 32'(sel), 32'd7);
    rst = 1'b1;
    step();
    chk("rs_sel", 32'(sel), 32'd0);
    chk("rs_gate", 32'(gate_en), 32'd1);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    chk("rs_ready", 32'(req_ready), 32'd1);
    nd = 0;
    for (int i = 0; i < G + S; i++) begin
      step();
      if (done === 1'b1) nd++;
    end
    chk("rs_no_done", nd, 0);

    // N_IN=12 instance: out-of-range, no-op, and a real switch
    v12 = 1'b1; s12 = 4'd13;
    step();
    v12 = 1'b0;
    chk("oor_err", 32'(err12), 32'd1);
    chk("oor_sel", 32'(sel12), 32'd0);
    chk("oor_done", 32'(done12), 32'd0);
    chk("oor_ready", 32'(rdy12), 32'd1);
    step();
    chk("oor_err_clr", 32'(err12), 32'd0);
    chk("oor_done_clr", 32'(done12), 32'd0);
    v12 = 1'b1; s12 = 4'd0;
    step();
    v12 = 1'b0;
    chk("n12_noop_done", 32'(done12), 32'd1);
    chk("n12_noop_err", 32'(err12), 32'd0);
    v12 = 1'b1; s12 = 4'd11;
    step();
    v12 = 1'b0;
    chk("n12_gate", 32'(gate12), 32'd0);
    chk("n12_busy", 32'(busy12), 32'd1);
    for (int i = 0; i < G + S; i++) step();
    chk("n12_done", 32'(done12), 32'd1);
    chk("n12_sel", 32'(sel12), 32'd11);
    chk("n12_gate_back", 32'(gate12), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
